// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
// Time-multiplexed scan controller for a four-digit seven-segment display.
// It steps the nibble-multiplexer select, decodes the returned nibble to hex
// segments, and drives active-low anodes, decimal point and a frame strobe.
//
// Optional feature macro: SCAN_BLANKING_EN
//   Defined:   each digit slot begins with BLANK_CYCLES cycles of all anodes
//              off, which suppresses ghosting while the segment lines settle.
//   Undefined: anodes switch straight from one digit to the next; BLANK_CYCLES
//              only takes part in sizing the prescaler.
//
// Parameters:
//   REFRESH_DIVIDE  clock cycles per digit slot (must exceed BLANK_CYCLES)
//   BLANK_CYCLES    leading all-off cycles per slot (>= 1)
// Ports:
//   clock      in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   enable     in   1: digits lit, 0: anodes off (scan keeps running)
//   nibbleIn   in   [3:0] nibble chosen by the multiplexer for selector
//   dpMask     in   [3:0] decimal point requests, bit 3 = leftmost digit
//   selector   out  [1:0] multiplexer select, 2'b11 = leftmost digit
//   anodes     out  [3:0] active-low digit enables, bit 3 = leftmost digit
//   segments   out  [6:0] {g,f,e,d,c,b,a}, active-low
//   dp         out  decimal point, active-low
//   frameDone  out  one-cycle pulse once all four digits have been shown
module seven_segment_scanner #(
    parameter int unsigned REFRESH_DIVIDE = 100000,
    parameter int unsigned BLANK_CYCLES   = 1000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [3:0] nibbleIn,
    input  logic [3:0] dpMask,
    output logic [1:0] selector,
    output logic [3:0] anodes,
    output logic [6:0] segments,
    output logic       dp,
    output logic       frameDone
);

    // The prescaler is wide enough for the slot and for the blanking compare.
    localparam int unsigned CNT_SPAN = (REFRESH_DIVIDE > BLANK_CYCLES) ?
                                       REFRESH_DIVIDE : (BLANK_CYCLES + 32'd1);
    localparam int unsigned CNT_W    = (CNT_SPAN > 32'd2) ? $clog2(CNT_SPAN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIVIDE - 32'd1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Hex digit to active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0] count_r;
    logic             slot_end_s;
    logic [1:0]       selector_r;
    logic             frame_done_r;
    logic [3:0]       anodes_r;
    logic [6:0]       segments_r;
    logic             dp_r;
    logic [3:0]       digit_mask_s;
    logic [3:0]       anodes_next_s;
    state_t           state_s;

    assign slot_end_s = (count_r == CNT_LAST);

    // Prescaler: counts through one digit slot and wraps.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r <= '0;
        end else if (slot_end_s) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    // Digit select walks 11 -> 10 -> 01 -> 00 -> 11; the 00 -> 11 step marks a frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            selector_r   <= 2'b11;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= slot_end_s && (selector_r == 2'b00);
            if (slot_end_s) begin
                selector_r <= selector_r - 2'd1;
            end else begin
                selector_r <= selector_r;
            end
        end
    end

`ifdef SCAN_BLANKING_EN
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 32'd1);

    state_t state_r;
    state_t state_next_s;

    // Blank/show state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_BLANK;
        end else begin
            state_r <= state_next_s;
        end
    end

    // BLANK covers counts 0..BLANK_CYCLES-1; SHOW runs to the end of the slot.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_BLANK: begin
                if (count_r == BLANK_LAST) begin
                    state_next_s = ST_SHOW;
                end else begin
                    state_next_s = ST_BLANK;
                end
            end
            ST_SHOW: begin
                if (slot_end_s) begin
                    state_next_s = ST_BLANK;
                end else begin
                    state_next_s = ST_SHOW;
                end
            end
            default: state_next_s = ST_BLANK;
        endcase
    end

    assign state_s = state_r;
`else
    assign state_s = ST_SHOW;
`endif

    // One-hot-low anode pattern for the digit currently selected.
    always_comb begin
        digit_mask_s = 4'b1111;
        case (selector_r)
            2'b11:   digit_mask_s = 4'b0111;
            2'b10:   digit_mask_s = 4'b1011;
            2'b01:   digit_mask_s = 4'b1101;
            2'b00:   digit_mask_s = 4'b1110;
            default: digit_mask_s = 4'b1111;
        endcase
    end

    // Light the digit only while showing and enabled.
    always_comb begin
        anodes_next_s = 4'b1111;
        if ((state_s == ST_SHOW) && enable) begin
            anodes_next_s = digit_mask_s;
        end else begin
            anodes_next_s = 4'b1111;
        end
    end

    // Display outputs are registered together so anodes and segments move on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            anodes_r   <= 4'b1111;
            segments_r <= 7'h7F;
            dp_r       <= 1'b1;
        end else begin
            anodes_r   <= anodes_next_s;
            segments_r <= seg_decode(nibbleIn);
            dp_r       <= ~dpMask[selector_r];
        end
    end

    assign selector  = selector_r;
    assign frameDone = frame_done_r;
    assign anodes    = anodes_r;
    assign segments  = segments_r;
    assign dp        = dp_r;

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed scan controller for the four-digit seven-segment display. It drives the 2-bit `selector` of the 4-bit, 4-input nibble multiplexer, takes the selected nibble back, and decodes it to hex segment patterns. It also generates the active-low digit anodes and a per-frame strobe. It sits directly downstream of the nibble multiplexer and is the last logic stage before the board display pins.

## Interface
- `REFRESH_DIVIDE`, default 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); must exceed `BLANK_CYCLES`.
- `BLANK_CYCLES`, default 1000: leading cycles of each slot with all anodes off; ≥1; used only with `SCAN_BLANKING_EN`.
- `clock`  input  1  system clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `enable`  input  1  high: digits lit; low: all anodes off, scanning continues.
- `nibbleIn`  input  4  nibble currently selected by the multiplexer (combinational return path).
- `dpMask`  input  4  per-digit decimal point request, active-high; bit 3 is the leftmost digit.
- `selector`  output  2  multiplexer select; 2'b11 = leftmost digit (nibbleA) … 2'b00 = rightmost (nibbleD).
- `anodes`  output  4  digit enables, active-low; bit 3 is the leftmost digit.
- `segments`  output  7  {g,f,e,d,c,b,a}, active-low.
- `dp`  output  1  decimal point, active-low.
- `frameDone`  output  1  one-cycle pulse after all four digits have been shown.

## Operation
- Reset values: `selector`=2'b11, `anodes`=4'b1111, `segments`=7'h7F, `dp`=1, `frameDone`=0. Prescaler count is 0. FSM is in BLANK when the macro is defined, otherwise SHOW.
- Prescaler runs 0..`REFRESH_DIVIDE`-1 and wraps. The wrap cycle (count = `REFRESH_DIVIDE`-1) ends the slot.
- At slot end, `selector` steps 11→10→01→00→11. `frameDone` pulses for one cycle on the edge where `selector` goes 00→11.
- FSM states:
  - BLANK: count < `BLANK_CYCLES`; anodes forced off.
  - SHOW: remaining cycles of the slot.
  - BLANK→SHOW when count reaches `BLANK_CYCLES`. SHOW→BLANK at slot end.
- Decode is standard hex 0–F:
  - 0=7'h40, 1=7'h79, 2=7'h24, 3=7'h30, 4=7'h19, 5=7'h12, 6=7'h02, 7=7'h78
  - 8=7'h00, 9=7'h10, A=7'h08, b=7'h03, C=7'h46, d=7'h21, E=7'h06, F=7'h0E
- `dp` = ~`dpMask`[digit index], where digit index 3 corresponds to `selector` 11.
- `anodes` is the one-hot-low digit for the delayed `selector` while in SHOW with `enable`=1. Otherwise it is 4'b1111.
- `enable` low does not stop the prescaler, `selector` stepping, or `frameDone`.
- `reset` asserted mid-slot returns every register to its reset value on the next edge. The scan restarts at the leftmost digit.

## Timing
- `selector` is registered. `nibbleIn` is valid combinationally in the same cycle.
- `segments`, `dp` and `anodes` are registered from that cycle's `nibbleIn`/state. They lag `selector` by exactly one cycle, so anodes and segments always change on the same edge.
- Digit slot = `REFRESH_DIVIDE` cycles. Frame = 4×`REFRESH_DIVIDE` cycles. `frameDone` period is the same.
- Lit time per slot:
  - With `SCAN_BLANKING_EN`: `REFRESH_DIVIDE`−`BLANK_CYCLES` cycles.
  - Without it: `REFRESH_DIVIDE` cycles.
- A change on `nibbleIn` or `dpMask` appears on the outputs one cycle later.

## Configuration
- `SCAN_BLANKING_EN` defined:
  - Each slot starts with `BLANK_CYCLES` cycles of `anodes`=4'b1111, which suppresses ghosting while the multiplexer and segment lines settle.
- Not defined:
  - FSM stays in SHOW, and `BLANK_CYCLES` is ignored.
  - Anodes switch directly from one digit to the next on the edge after `selector` changes. No all-off cycle occurs except when `enable`=0.

## Test plan
- Reset: hold `reset` 3 cycles mid-scan → all outputs at reset values. First release cycle shows `selector`=11. With the macro defined, `anodes` stays 4'b1111 for 2+1 cycles (params 8/2).
- Scan order (`REFRESH_DIVIDE`=8, `BLANK_CYCLES`=2, macro on, mux nibbles A=1,B=2,C=3,D=4):
  - `selector` sequence is 11,10,01,00, 8 cycles each.
  - `anodes` sequence is 0111,1011,1101,1110, 6 lit cycles each, with `segments` 79,24,30,19 respectively.
- Frame strobe: same setup → `frameDone` high exactly one cycle every 32 cycles, coincident with `selector` 00→11.
- Decode sweep: force `nibbleIn` 0..F while `selector`=11 → `segments` matches the table one cycle later.
- `dpMask`=4'b0101 → `dp`=0 only while `anodes`=1011 or 1110.
- `enable`=0 for one full frame → `anodes`=1111 throughout, while `selector` and `frameDone` continue unchanged. Macro off → no all-off cycles between digits when `enable`=1.
